// File: rtl/busy_ctr_multi.sv
// NUM_CH independent busy-window down-counters sharing one start port and one abort port.
// Each channel supports hold (pause), abort, and emits a registered done pulse on natural expiry.
module busy_ctr_multi #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEFAULT_AMOUNT = 22,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start__ENA,
  output logic              start__RDY,
  input  logic [CH_W-1:0]   start_ch,
  input  logic [WIDTH-1:0]  start_amount,
  input  logic              abort__ENA,
  output logic              abort__RDY,
  input  logic [CH_W-1:0]   abort_ch,
  input  logic [NUM_CH-1:0] hold,
  output logic [NUM_CH-1:0] busy,
  output logic              busy__RDY,
  output logic              any_busy,
  output logic [NUM_CH-1:0] done
);

  logic [NUM_CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            done_q, done_d;
  logic [NUM_CH-1:0]            start_sel, abort_sel;
  logic [NUM_CH-1:0]            start_hit, abort_hit;
  logic [WIDTH-1:0]             load_amt;

  // Channel decode; an out-of-range channel number matches no channel at all.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      start_sel[i] = (start_ch == CH_W'(i));
      abort_sel[i] = (abort_ch == CH_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign any_busy   = |busy;
  assign start__RDY = |(start_sel & ~busy);
  assign abort__RDY = 1'b1;
  assign busy__RDY  = 1'b1;
  assign done       = done_q;

  assign load_amt  = (start_amount != '0) ? start_amount : WIDTH'(DEFAULT_AMOUNT);
  assign start_hit = (start__ENA && start__RDY) ? start_sel : '0;
  assign abort_hit = abort__ENA ? abort_sel : '0;

  // A start only hits an idle channel, where abort is a no-op, so start may take precedence here.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (start_hit[i]) begin
        cnt_d[i] = load_amt;
      end else if (abort_hit[i]) begin
        cnt_d[i] = '0;
      end else if (busy[i] && !hold[i]) begin
        cnt_d[i] = cnt_q[i] - WIDTH'(1);
      end
      done_d[i] = (cnt_q[i] == WIDTH'(1)) && !hold[i] && !abort_hit[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      done_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef FORMAL
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      assert (!(done_q[i] && busy[i]));
      if (start__RDY && start_sel[i]) assert (!busy[i]);
    end
  end
`endif

endmodule

// File: tb/tb_busy_ctr_multi.sv
// Self-checking bench for busy_ctr_multi: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic against a progress-based reference model.
module tb_busy_ctr_multi;

  localparam int NCH  = 4;
  localparam int DEFA = 22;

  logic        CLK, RST;
  logic        start__ENA, start__RDY, abort__ENA, abort__RDY, busy__RDY, any_busy;
  logic [1:0]  start_ch, abort_ch;
  logic [15:0] start_amount;
  logic [3:0]  hold, busy, done;

  busy_ctr_multi dut (
    .CLK(CLK), .RST(RST),
    .start__ENA(start__ENA), .start__RDY(start__RDY), .start_ch(start_ch),
    .start_amount(start_amount),
    .abort__ENA(abort__ENA), .abort__RDY(abort__RDY), .abort_ch(abort_ch),
    .hold(hold), .busy(busy), .busy__RDY(busy__RDY), .any_busy(any_busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  // Reference model: a channel is an active job with a target length and consumed cycles.
  bit m_act [NCH];
  int m_amt [NCH];
  int m_prog[NCH];

  int   bc[NCH];
  int   dc[NCH];
  int   abc;
  logic last_rdy;

  typedef struct {
    logic        se;
    logic [1:0]  sc;
    logic [15:0] sa;
    logic        ae;
    logic [1:0]  ac;
    logic [3:0]  h;
    logic        exp_rdy;
    logic [3:0]  exp_busy;
    logic [3:0]  exp_done;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic se, logic [1:0] sc, logic [15:0] sa, logic ae,
                              logic [1:0] ac, logic [3:0] h, logic r, logic [3:0] b,
                              logic [3:0] d);
    vec_t v;
    v.se = se; v.sc = sc; v.sa = sa; v.ae = ae; v.ac = ac; v.h = h;
    v.exp_rdy = r; v.exp_busy = b; v.exp_done = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 1'b0; m_amt[i] = 0; m_prog[i] = 0;
    end
  endtask

  // One clock: drive, check ready before the edge, advance model, check outputs after the edge.
  task automatic step(input logic se, input logic [1:0] sc, input logic [15:0] sa,
                      input logic ae, input logic [1:0] ac, input logic [3:0] h);
    logic       rdy;
    logic [3:0] eb, ed;
    start__ENA = se; start_ch = sc; start_amount = sa;
    abort__ENA = ae; abort_ch = ac; hold = h;
    rdy = !m_act[sc];
    #1;
    last_rdy = start__RDY;
    chk("start_rdy", 32'(start__RDY), 32'(rdy));
    @(posedge CLK);
    for (int i = 0; i < NCH; i++) begin
      bit ab, st;
      ab = ae && (int'(ac) == i);
      st = se && rdy && (int'(sc) == i);
      ed[i] = m_act[i] && (m_amt[i] - m_prog[i] == 1) && !h[i] && !ab;
      if (st) begin
        m_act[i] = 1'b1; m_amt[i] = (sa == 16'd0) ? DEFA : int'(sa); m_prog[i] = 0;
      end else if (ab) begin
        m_act[i] = 1'b0;
      end else if (m_act[i] && !h[i]) begin
        m_prog[i]++;
        if (m_prog[i] == m_amt[i]) m_act[i] = 1'b0;
      end
      eb[i] = m_act[i];
    end
    #1;
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    chk("any_busy", 32'(any_busy), 32'(|eb));
    for (int i = 0; i < NCH; i++) begin
      if (busy[i]) bc[i]++;
      if (done[i]) dc[i]++;
    end
    if (any_busy) abc++;
  endtask

  task automatic idle(input int n, input logic [1:0] sc);
    for (int k = 0; k < n; k++) step(1'b0, sc, 16'd0, 1'b0, 2'd0, 4'd0);
  endtask

  int b0, d0, a0;
  int dd[NCH];

  initial begin
    RST = 1'b1;
    start__ENA = 1'b0; start_ch = 2'd0; start_amount = 16'd0;
    abort__ENA = 1'b0; abort_ch = 2'd0; hold = 4'd0;
    for (int i = 0; i < NCH; i++) begin bc[i] = 0; dc[i] = 0; end
    abc = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_any", 32'(any_busy), 32'd0);
    chk("rst_rdy", 32'(start__RDY), 32'd1);
    chk("abort_rdy", 32'(abort__RDY), 32'd1);
    chk("busy_rdy", 32'(busy__RDY), 32'd1);
    RST = 1'b0;

    // Directed table: basic count, abort, collision, abort+start, hold.
    vecs[0]  = mk(1, 0, 16'd5, 0, 0, 4'b0000, 1, 4'b0001, 4'b0000);
    vecs[1]  = mk(0, 0, 16'd0, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000);
    vecs[2]  = mk(0, 0, 16'd0, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000);
    vecs[3]  = mk(0, 0, 16'd0, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000);
    vecs[4]  = mk(0, 0, 16'd0, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000);
    vecs[5]  = mk(0, 0, 16'd0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0001);
    vecs[6]  = mk(0, 0, 16'd0, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000);
    vecs[7]  = mk(1, 0, 16'd6, 0, 0, 4'b0000, 1, 4'b0001, 4'b0000);
    vecs[8]  = mk(0, 0, 16'd0, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000);
    vecs[9]  = mk(0, 0, 16'd0, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000);
    vecs[10] = mk(0, 0, 16'd0, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000);
    vecs[11] = mk(1, 1, 16'd2, 1, 0, 4'b0000, 1, 4'b0010, 4'b0000);
    vecs[12] = mk(1, 1, 16'd9, 0, 0, 4'b0000, 0, 4'b0010, 4'b0000);
    vecs[13] = mk(0, 1, 16'd0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0010);
    vecs[14] = mk(1, 2, 16'd3, 1, 2, 4'b0000, 1, 4'b0100, 4'b0000);
    vecs[15] = mk(0, 2, 16'd0, 0, 0, 4'b0100, 0, 4'b0100, 4'b0000);
    vecs[16] = mk(0, 2, 16'd0, 0, 0, 4'b0000, 0, 4'b0100, 4'b0000);
    vecs[17] = mk(0, 2, 16'd0, 0, 0, 4'b0000, 0, 4'b0100, 4'b0000);
    vecs[18] = mk(0, 2, 16'd0, 0, 0, 4'b0100, 0, 4'b0100, 4'b0000);
    vecs[19] = mk(0, 2, 16'd0, 1, 3, 4'b0000, 0, 4'b0000, 4'b0100);
    for (int v = 0; v < 20; v++) begin
      step(vecs[v].se, vecs[v].sc, vecs[v].sa, vecs[v].ae, vecs[v].ac, vecs[v].h);
      chk($sformatf("vec%0d_rdy", v), 32'(last_rdy), 32'(vecs[v].exp_rdy));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      chk($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
    end

    // Asynchronous reset mid-count with ch2 at 9.
    step(1'b1, 2'd2, 16'd12, 1'b0, 2'd0, 4'd0);
    idle(3, 2'd2);
    RST = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    d0 = dc[2];
    idle(4, 2'd2);
    chk("rst_no_done", 32'(dc[2] - d0), 32'd0);

    // Default amount, minimum amount, full-width amount on ch1.
    b0 = bc[1]; d0 = dc[1];
    step(1'b1, 2'd1, 16'd0, 1'b0, 2'd0, 4'd0);
    idle(25, 2'd0);
    chk("default_len", 32'(bc[1] - b0), 32'd22);
    chk("default_done", 32'(dc[1] - d0), 32'd1);
    b0 = bc[1]; d0 = dc[1];
    step(1'b1, 2'd1, 16'd1, 1'b0, 2'd0, 4'd0);
    idle(3, 2'd0);
    chk("amt1_len", 32'(bc[1] - b0), 32'd1);
    chk("amt1_done", 32'(dc[1] - d0), 32'd1);
    b0 = bc[1]; d0 = dc[1];
    step(1'b1, 2'd1, 16'hFFFF, 1'b0, 2'd0, 4'd0);
    idle(65537, 2'd0);
    chk("max_len", 32'(bc[1] - b0), 32'd65535);
    chk("max_done", 32'(dc[1] - d0), 32'd1);

    // Hold on ch3 for three cycles after the second busy cycle, then hold at count 1.
    b0 = bc[3]; d0 = dc[3];
    step(1'b1, 2'd3, 16'd4, 1'b0, 2'd0, 4'd0);
    idle(1, 2'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 4'b1000);
    idle(4, 2'd0);
    chk("hold_len", 32'(bc[3] - b0), 32'd7);
    chk("hold_done", 32'(dc[3] - d0), 32'd1);
    b0 = bc[3]; d0 = dc[3];
    step(1'b1, 2'd3, 16'd2, 1'b0, 2'd0, 4'd0);
    idle(1, 2'd0);
    for (int k = 0; k < 2; k++) step(1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 4'b1000);
    chk("hold1_no_done", 32'(dc[3] - d0), 32'd0);
    idle(2, 2'd0);
    chk("hold1_len", 32'(bc[3] - b0), 32'd4);
    chk("hold1_done", 32'(dc[3] - d0), 32'd1);

    // Four staggered starts, then restart of ch0 on its done cycle.
    a0 = abc;
    for (int i = 0; i < NCH; i++) dd[i] = dc[i];
    for (int i = 0; i < NCH; i++) step(1'b1, 2'(i), 16'd3, 1'b0, 2'd0, 4'd0);
    idle(4, 2'd0);
    chk("par_any_len", 32'(abc - a0), 32'd6);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("par_done%0d", i), 32'(dc[i] - dd[i]), 32'd1);
    step(1'b1, 2'd0, 16'd3, 1'b0, 2'd0, 4'd0);
    idle(3, 2'd0);
    chk("restart_done_seen", 32'(done), 32'b0001);
    step(1'b1, 2'd0, 16'd3, 1'b0, 2'd0, 4'd0);
    chk("restart_rdy", 32'(last_rdy), 32'd1);
    chk("restart_busy", 32'(busy), 32'b0001);
    idle(4, 2'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] h;
      for (int i = 0; i < NCH; i++) h[i] = ($urandom % 6 == 0);
      step(($urandom % 3 == 0), 2'($urandom % 4),
           ($urandom % 5 == 0) ? 16'd0 : 16'($urandom_range(1, 12)),
           ($urandom % 10 == 0), 2'($urandom % 4), h);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
